// File: rtl/sdcard_clk_pkg.sv
// Shared definitions for the SD clock manager.
//   clk_mgr_state_t : sequencer state encoding
//   PWR_DOWN        : power_state_i code that forces the SD clock off
//   DEF_*_DIV       : default divider after reset and legal divider range
//   TIMER_W         : width of the shared cycle timer
package sdcard_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CAL    = 3'd4,
    ST_PWRDN  = 3'd5
  } clk_mgr_state_t;

  localparam logic [1:0]  PWR_DOWN     = 2'b11;
  localparam logic [15:0] DEF_INIT_DIV = 16'h007F;
  localparam logic [15:0] DEF_MIN_DIV  = 16'h0001;
  localparam logic [15:0] DEF_MAX_DIV  = 16'h00C8;

  // Wide enough for the largest interval (calibration timeout).
  localparam int TIMER_W = 16;

endpackage

// File: rtl/sdcard_cycle_timer.sv
// Loadable down-counter shared by all timed phases of the clock manager.
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_value (takes priority over tick)
//   load_value  : interval minus one; done rises after load_value ticks
//   tick        : count down by one (saturates at zero)
//   done        : count has reached zero
module sdcard_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/sdcard_clock_manager.sv
// Sequencer for the SD clock generator controls (enable, divider, calibration).
// Frequency changes arrive on a valid/ready handshake and are applied as
// stop -> drain -> load -> settle -> optional calibration. Between changes the
// SD clock is auto-gated while the engines are idle and forced off in power-down.
//   PCLK_i, PRESETn_i       : clock, asynchronous active-low reset
//   freq_req_i/div_i/cal_i  : request valid, divider, calibrate-after-switch
//   freq_rdy_o              : request ready (combinational)
//   freq_ack_o/freq_err_o   : one-cycle completion pulse and error qualifier
//   cmd_active_i/dat_active_i, auto_gate_en_i, power_state_i : gating inputs
//   clk_enable_o/clk_divider_o/cal_start_o : generator controls
//   cal_done_i/cal_result_i : calibration response; cal_result_o holds last result
//   busy_o                  : switch or calibration in progress
module sdcard_clock_manager
  import sdcard_clk_pkg::*;
#(
  parameter int               DIV_W            = 16,
  parameter logic [DIV_W-1:0] INIT_DIV         = DIV_W'(DEF_INIT_DIV),
  parameter logic [DIV_W-1:0] MIN_DIV          = DIV_W'(DEF_MIN_DIV),
  parameter logic [DIV_W-1:0] MAX_DIV          = DIV_W'(DEF_MAX_DIV),
  parameter int               STOP_CYCLES      = 4,
  parameter int               SETTLE_CYCLES    = 16,
  parameter int               GATE_IDLE_CYCLES = 64,
  parameter int               CAL_TIMEOUT      = 1024
) (
  input  logic             PCLK_i,
  input  logic             PRESETn_i,
  input  logic             freq_req_i,
  input  logic [DIV_W-1:0] freq_div_i,
  input  logic             freq_cal_i,
  output logic             freq_rdy_o,
  output logic             freq_ack_o,
  output logic             freq_err_o,
  input  logic             cmd_active_i,
  input  logic             dat_active_i,
  input  logic             auto_gate_en_i,
  input  logic [1:0]       power_state_i,
  output logic             clk_enable_o,
  output logic [DIV_W-1:0] clk_divider_o,
  output logic             cal_start_o,
  input  logic             cal_done_i,
  input  logic [DIV_W-1:0] cal_result_i,
  output logic [DIV_W-1:0] cal_result_o,
  output logic             busy_o
);

  clk_mgr_state_t state_reg, state_next;

  logic [DIV_W-1:0]   divider_reg, pend_div_reg, cal_result_reg;
  logic               pend_cal_reg, clk_enable_reg, busy_reg, cal_start_reg;
  logic               ack_reg, err_reg;
  logic               ack_next, err_next, commit, capture, latch_req;
  logic               tmr_load, tmr_tick, tmr_done;
  logic [TIMER_W-1:0] tmr_value;
  logic               power_down, activity, accept, div_legal, want_clock;

  assign power_down = (power_state_i == PWR_DOWN);
  assign activity   = cmd_active_i | dat_active_i;
  // Without auto-gating the clock is wanted permanently.
  assign want_clock = activity | ~auto_gate_en_i;
  assign freq_rdy_o = ((state_reg == ST_IDLE) || (state_reg == ST_RUN)) && !power_down;
  assign accept     = freq_req_i && freq_rdy_o;
  assign div_legal  = (freq_div_i >= MIN_DIV) && (freq_div_i <= MAX_DIV);

  sdcard_cycle_timer #(.W(TIMER_W)) u_timer (
    .clk        (PCLK_i),
    .rst_n      (PRESETn_i),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tick       (tmr_tick),
    .done       (tmr_done)
  );

  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    commit     = 1'b0;
    capture    = 1'b0;
    latch_req  = 1'b0;
    tmr_load   = 1'b0;
    tmr_tick   = 1'b0;
    tmr_value  = '0;

    if (power_down) begin
      // Abort anything in flight; the divider is left at its last committed value.
      state_next = ST_PWRDN;
      if ((state_reg == ST_DRAIN) || (state_reg == ST_SETTLE) || (state_reg == ST_CAL)) begin
        ack_next = 1'b1;
        err_next = 1'b1;
      end
    end else begin
      case (state_reg)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            // A rejected request leaves state and idle timer untouched.
            if (div_legal) begin
              latch_req  = 1'b1;
              state_next = ST_DRAIN;
            end else begin
              ack_next = 1'b1;
              err_next = 1'b1;
            end
          end else if (state_reg == ST_IDLE) begin
            if (want_clock) state_next = ST_RUN;
          end else if (want_clock) begin
            tmr_load  = 1'b1;
            tmr_value = TIMER_W'(GATE_IDLE_CYCLES - 1);
          end else if (tmr_done) begin
            state_next = ST_IDLE;
          end else begin
            tmr_tick = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (tmr_done) begin
            commit     = 1'b1;
            state_next = ST_SETTLE;
          end else begin
            tmr_tick = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            if (pend_cal_reg) begin
              state_next = ST_CAL;
            end else begin
              ack_next   = 1'b1;
              state_next = ST_RUN;
            end
          end else begin
            tmr_tick = 1'b1;
          end
        end
        ST_CAL: begin
          if (cal_done_i) begin
            capture    = 1'b1;
            ack_next   = 1'b1;
            state_next = ST_RUN;
          end else if (tmr_done) begin
            ack_next   = 1'b1;
            err_next   = 1'b1;
            state_next = ST_RUN;
          end else begin
            tmr_tick = 1'b1;
          end
        end
        ST_PWRDN: state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end

    // Every state entry restarts the shared timer with that state's interval.
    if (state_next != state_reg) begin
      tmr_load = 1'b1;
      tmr_tick = 1'b0;
      case (state_next)
        ST_DRAIN:  tmr_value = TIMER_W'(STOP_CYCLES - 1);
        ST_SETTLE: tmr_value = TIMER_W'(SETTLE_CYCLES - 1);
        ST_CAL:    tmr_value = TIMER_W'(CAL_TIMEOUT - 1);
        ST_RUN:    tmr_value = TIMER_W'(GATE_IDLE_CYCLES - 1);
        default:   tmr_value = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_reg      <= ST_IDLE;
      divider_reg    <= INIT_DIV;
      pend_div_reg   <= INIT_DIV;
      pend_cal_reg   <= 1'b0;
      cal_result_reg <= '0;
      clk_enable_reg <= 1'b0;
      busy_reg       <= 1'b0;
      cal_start_reg  <= 1'b0;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      // Outputs decode the next state so they change on the same edge as the state.
      clk_enable_reg <= (state_next == ST_RUN) || (state_next == ST_SETTLE) ||
                        (state_next == ST_CAL);
      busy_reg       <= (state_next == ST_DRAIN) || (state_next == ST_SETTLE) ||
                        (state_next == ST_CAL);
      cal_start_reg  <= (state_next == ST_CAL) && (state_reg != ST_CAL);
      ack_reg        <= ack_next;
      err_reg        <= err_next;
      if (latch_req) begin
        pend_div_reg <= freq_div_i;
        pend_cal_reg <= freq_cal_i;
      end
      if (commit)  divider_reg    <= pend_div_reg;
      if (capture) cal_result_reg <= cal_result_i;
    end
  end

  assign clk_enable_o  = clk_enable_reg;
  assign clk_divider_o = divider_reg;
  assign cal_start_o   = cal_start_reg;
  assign freq_ack_o    = ack_reg;
  assign freq_err_o    = err_reg;
  assign cal_result_o  = cal_result_reg;
  assign busy_o        = busy_reg;

endmodule

// File: tb/tb_sdcard_clock_manager.sv
// Self-checking bench for sdcard_clock_manager: a timeline model of the
// expected behaviour is compared against the DUT every cycle, and directed
// scenarios pin key cycles with literal expectations.
module tb_sdcard_clock_manager;

  localparam int STOP   = 4;
  localparam int SETTLE = 16;
  localparam int GATE   = 64;
  localparam int CALTO  = 1024;

  localparam int M_GATED  = 0;
  localparam int M_RUN    = 1;
  localparam int M_SWITCH = 2;
  localparam int M_CAL    = 3;
  localparam int M_PWR    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freq_req, freq_cal, cmd_active, dat_active, auto_gate_en, cal_done;
  logic [15:0] freq_div, cal_res_in;
  logic [1:0]  power_state;
  logic        freq_rdy_o, freq_ack_o, freq_err_o, clk_enable_o, cal_start_o, busy_o;
  logic [15:0] clk_divider_o, cal_result_o;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model state: mode plus timestamps of the current request.
  int          cyc, acc_cyc, cal_entry, idle_cnt, mode;
  logic [15:0] m_div, m_new_div, m_cal_res;
  logic        m_cal_req, e_ack, e_err, e_cal_start;

  always #5 clk = ~clk;

  sdcard_clock_manager dut (
    .PCLK_i         (clk),
    .PRESETn_i      (rst_n),
    .freq_req_i     (freq_req),
    .freq_div_i     (freq_div),
    .freq_cal_i     (freq_cal),
    .freq_rdy_o     (freq_rdy_o),
    .freq_ack_o     (freq_ack_o),
    .freq_err_o     (freq_err_o),
    .cmd_active_i   (cmd_active),
    .dat_active_i   (dat_active),
    .auto_gate_en_i (auto_gate_en),
    .power_state_i  (power_state),
    .clk_enable_o   (clk_enable_o),
    .clk_divider_o  (clk_divider_o),
    .cal_start_o    (cal_start_o),
    .cal_done_i     (cal_done),
    .cal_result_i   (cal_res_in),
    .cal_result_o   (cal_result_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_enable();
    return (mode == M_RUN) || (mode == M_CAL) ||
           ((mode == M_SWITCH) && (cyc - acc_cyc > STOP));
  endfunction

  function automatic logic exp_busy();
    return (mode == M_SWITCH) || (mode == M_CAL);
  endfunction

  function automatic logic exp_ready();
    return ((mode == M_GATED) || (mode == M_RUN)) && (power_state != 2'b11);
  endfunction

  // Advance the model by the clock edge that just occurred, using the inputs
  // that were present during the cycle that ended.
  task automatic model_update();
    int  off;
    logic act, want, rdy, legal;
    act   = cmd_active | dat_active;
    want  = act | ~auto_gate_en;
    rdy   = exp_ready();
    legal = (freq_div >= 16'd1) && (freq_div <= 16'd200);
    e_ack = 1'b0; e_err = 1'b0; e_cal_start = 1'b0;
    if (power_state == 2'b11) begin
      if ((mode == M_SWITCH) || (mode == M_CAL)) begin
        e_ack = 1'b1; e_err = 1'b1;
      end
      mode = M_PWR;
    end else begin
      case (mode)
        M_PWR: mode = M_GATED;
        M_GATED, M_RUN: begin
          if (freq_req && rdy) begin
            if (legal) begin
              mode = M_SWITCH; acc_cyc = cyc; m_new_div = freq_div; m_cal_req = freq_cal;
            end else begin
              e_ack = 1'b1; e_err = 1'b1;
            end
          end else if (mode == M_GATED) begin
            if (want) begin mode = M_RUN; idle_cnt = 0; end
          end else if (want) begin
            idle_cnt = 0;
          end else begin
            idle_cnt++;
            if (idle_cnt == GATE) mode = M_GATED;
          end
        end
        M_SWITCH: begin
          off = cyc + 1 - acc_cyc;
          if (off == STOP + 1) m_div = m_new_div;
          if (off == STOP + SETTLE + 1) begin
            if (m_cal_req) begin
              mode = M_CAL; e_cal_start = 1'b1; cal_entry = cyc + 1;
            end else begin
              mode = M_RUN; e_ack = 1'b1; idle_cnt = 0;
            end
          end
        end
        M_CAL: begin
          if (cal_done) begin
            m_cal_res = cal_res_in; e_ack = 1'b1; mode = M_RUN; idle_cnt = 0;
          end else if (cyc + 1 - cal_entry == CALTO) begin
            e_ack = 1'b1; e_err = 1'b1; mode = M_RUN; idle_cnt = 0;
          end
        end
        default: mode = M_GATED;
      endcase
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Present a request for one cycle (ready is expected to be high).
  task automatic issue(input logic [15:0] div, input logic cal);
    freq_req = 1'b1; freq_div = div; freq_cal = cal;
    check("req_ready", 32'(freq_rdy_o), 1);
    step();
    freq_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_enable",     32'(clk_enable_o),  32'(exp_enable()));
      check("cmp_divider",    32'(clk_divider_o), 32'(m_div));
      check("cmp_ack",        32'(freq_ack_o),    32'(e_ack));
      check("cmp_err",        32'(freq_err_o),    32'(e_err));
      check("cmp_cal_start",  32'(cal_start_o),   32'(e_cal_start));
      check("cmp_cal_result", 32'(cal_result_o),  32'(m_cal_res));
      check("cmp_busy",       32'(busy_o),        32'(exp_busy()));
      check("cmp_ready",      32'(freq_rdy_o),    32'(exp_ready()));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; freq_req = 1'b0; freq_div = '0; freq_cal = 1'b0;
    cmd_active = 1'b0; dat_active = 1'b0; auto_gate_en = 1'b1;
    power_state = 2'b00; cal_done = 1'b0; cal_res_in = '0;
    cyc = 0; acc_cyc = 0; cal_entry = 0; idle_cnt = 0; mode = M_GATED;
    m_div = 16'h007F; m_new_div = 16'h007F; m_cal_res = '0; m_cal_req = 1'b0;
    e_ack = 1'b0; e_err = 1'b0; e_cal_start = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_enable",     32'(clk_enable_o),  0);
    check("rst_divider",    32'(clk_divider_o), 32'h007F);
    check("rst_ack",        32'(freq_ack_o),    0);
    check("rst_busy",       32'(busy_o),        0);
    check("rst_cal_result", 32'(cal_result_o),  0);

    // Activity in IDLE turns the clock on the next cycle.
    cmd_active = 1'b1;
    step();
    check("gate_on_activity", 32'(clk_enable_o), 1);
    check("init_divider",     32'(clk_divider_o), 32'h007F);

    // Legal switch to divider 1 without calibration.
    issue(16'h0001, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      if (k <= 4) check("drain_enable_low", 32'(clk_enable_o), 0);
      if (k == 5) check("new_divider", 32'(clk_divider_o), 1);
      if (k == 5) check("settle_enable", 32'(clk_enable_o), 1);
      check("switch_ack", 32'(freq_ack_o), 32'(k == 21));
      if (k == 21) check("switch_err", 32'(freq_err_o), 0);
      step();
    end

    // Out-of-range dividers (above and below range).
    issue(16'h00C9, 1'b0);
    check("illegal_ack",      32'(freq_ack_o),    1);
    check("illegal_err",      32'(freq_err_o),    1);
    check("illegal_keep_div", 32'(clk_divider_o), 1);
    check("illegal_no_busy",  32'(busy_o),        0);
    step();
    check("illegal_ack_once", 32'(freq_ack_o), 0);
    issue(16'h0000, 1'b0);
    check("zero_div_err", 32'(freq_err_o), 1);
    step();

    // Calibration completed 5 cycles after cal_start.
    issue(16'h0002, 1'b1);
    repeat (20) step();
    check("cal_start",     32'(cal_start_o),   1);
    check("cal_divider",   32'(clk_divider_o), 2);
    repeat (5) step();
    check("cal_wait_busy", 32'(busy_o), 1);
    cal_done = 1'b1; cal_res_in = 16'h0002;
    step();
    cal_done = 1'b0; cal_res_in = 16'h0000;
    check("cal_ack",    32'(freq_ack_o),   1);
    check("cal_err",    32'(freq_err_o),   0);
    check("cal_result", 32'(cal_result_o), 2);

    // Calibration timeout.
    issue(16'h0003, 1'b1);
    repeat (20) step();
    check("cal2_start", 32'(cal_start_o), 1);
    repeat (1023) step();
    check("cal_timeout_early", 32'(freq_ack_o), 0);
    step();
    check("cal_timeout_ack",  32'(freq_ack_o),    1);
    check("cal_timeout_err",  32'(freq_err_o),    1);
    check("cal_timeout_div",  32'(clk_divider_o), 3);
    check("cal_result_kept",  32'(cal_result_o),  2);

    // Request arriving on the 64th idle cycle wins over gating.
    cmd_active = 1'b0;
    repeat (63) step();
    check("idle63_enable", 32'(clk_enable_o), 1);
    issue(16'h0010, 1'b0);
    check("req_beats_gate_en",   32'(clk_enable_o), 0);
    check("req_beats_gate_busy", 32'(busy_o),       1);
    repeat (20) step();
    check("switch2_ack", 32'(freq_ack_o),    1);
    check("switch2_div", 32'(clk_divider_o), 32'h0010);

    // Auto-gating after 64 idle cycles, re-enable on activity.
    repeat (63) step();
    check("gate_not_yet", 32'(clk_enable_o), 1);
    step();
    check("gate_off", 32'(clk_enable_o), 0);
    repeat (2) step();
    dat_active = 1'b1;
    step();
    check("dat_wakes", 32'(clk_enable_o), 1);
    dat_active = 1'b0;
    repeat (64) step();
    check("gate_off2", 32'(clk_enable_o), 0);
    auto_gate_en = 1'b0;
    step();
    check("no_autogate_on", 32'(clk_enable_o), 1);
    auto_gate_en = 1'b1;

    // Power-down in DRAIN aborts the switch.
    cmd_active = 1'b1;
    issue(16'h0020, 1'b0);
    step();
    power_state = 2'b11;
    check("pd_ready", 32'(freq_rdy_o), 0);
    step();
    check("pd_ack",     32'(freq_ack_o),    1);
    check("pd_err",     32'(freq_err_o),    1);
    check("pd_enable",  32'(clk_enable_o),  0);
    check("pd_divider", 32'(clk_divider_o), 32'h0010);
    check("pd_ready2",  32'(freq_rdy_o),    0);
    step();
    check("pd_ack_once", 32'(freq_ack_o), 0);
    cmd_active = 1'b0;
    power_state = 2'b00;
    step();
    check("pd_release_enable", 32'(clk_enable_o),  0);
    check("pd_release_ready",  32'(freq_rdy_o),    1);
    check("pd_release_div",    32'(clk_divider_o), 32'h0010);
    repeat (3) step();

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
